// File: rtl/ldl_round_pkg.sv
// Shared helpers for the round-robin / priority arbiter family.
// Functions are written against a maximum width so that any
// arbiter size up to MAX_REQ requesters can reuse them.
package ldl_round_pkg;

  localparam int MAX_BIN_WIDTH = 8;
  localparam int MAX_REQ       = 1 << MAX_BIN_WIDTH;

  // Binary index of the set bit of a one-hot vector (0 when empty).
  function automatic int onehot2bin(input logic [MAX_REQ-1:0] vec);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[i]) idx = idx | i;
    end
    return idx;
  endfunction

  // First set bit of vec searching ptr+1, ptr+2, ... modulo n.
  // The bit at ptr itself is visited last, so the previous winner only
  // wins again when nothing else is requesting. Result is one-hot.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] vec,
                                                 input int ptr,
                                                 input int n);
    logic [MAX_REQ-1:0]       pick;
    logic                     found;
    logic [MAX_BIN_WIDTH-1:0] idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = MAX_BIN_WIDTH'((ptr + k) % n);
      if (k <= n && !found && vec[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational round-robin picker: eligible mask plus last-granted
// pointer in, one-hot winner out.
module ldl_rr_pick
  import ldl_round_pkg::*;
#(
  parameter  int BIN_WIDTH = 3,
  localparam int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic [REQ_WIDTH-1:0] eligible,
  input  logic [BIN_WIDTH-1:0] ptr,
  output logic [REQ_WIDTH-1:0] winner
);

  // Search starts just after the pointer and wraps around the requesters.
  always_comb begin
    winner = REQ_WIDTH'(rr_pick(MAX_REQ'(eligible), int'(ptr), REQ_WIDTH));
  end

endmodule

// File: rtl/ldl_round_pri_arb.sv
// N-way arbiter: strict priority by class of service, round-robin
// among requesters sharing the highest requesting class. The grant is
// registered and held until the downstream accepts it.
module ldl_round_pri_arb
  import ldl_round_pkg::*;
#(
  parameter  int BIN_WIDTH = 3,
  parameter  int COS_WIDTH = 2,
  localparam int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [REQ_WIDTH-1:0]                req,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos,
  input  logic                                ready,
  output logic [REQ_WIDTH-1:0]                hot,
  output logic [BIN_WIDTH-1:0]                bin,
  output logic                                valid
);

  logic [COS_WIDTH-1:0] max_cos;
  logic [REQ_WIDTH-1:0] eligible;
  logic [REQ_WIDTH-1:0] winner;
  logic [BIN_WIDTH-1:0] winner_bin;
  logic [BIN_WIDTH-1:0] ptr;
  logic                 load;

  // Highest class among active requesters; idle requesters do not count.
  always_comb begin
    max_cos = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      if (req[i] && cos[i] > max_cos) max_cos = cos[i];
    end
  end

  // Only requesters in the top class take part in the round-robin.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      eligible[i] = req[i] && (cos[i] == max_cos);
    end
  end

  ldl_rr_pick #(
    .BIN_WIDTH (BIN_WIDTH)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr),
    .winner   (winner)
  );

  // Encode the winner and decide whether the output stage may take a new grant.
  always_comb begin
    winner_bin = BIN_WIDTH'(onehot2bin(MAX_REQ'(winner)));
    load       = !valid || ready;
  end

  // Output and pointer registers; a stalled grant freezes everything.
  // The pointer is shared by all classes and only moves on a real grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      hot   <= '0;
      bin   <= '0;
      ptr   <= BIN_WIDTH'(REQ_WIDTH - 1);
    end else if (load) begin
      valid <= |req;
      if (|req) begin
        hot <= winner;
        bin <= winner_bin;
        ptr <= winner_bin;
      end else begin
        hot <= '0;
        bin <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ldl_round_pri_arb.sv
// Self-checking bench for ldl_round_pri_arb: a table of vectors with
// hand-derived expected grants, followed by hand-written sequences for
// back-pressure and mid-operation reset. Expectations go through a
// scoreboard queue and are compared one cycle after being driven.
module tb_ldl_round_pri_arb;

  logic            clk;
  logic            rst;
  logic [7:0]      req;
  logic [7:0][1:0] cos;
  logic            ready;
  logic [7:0]      hot;
  logic [2:0]      bin;
  logic            valid;

  typedef struct {
    logic [7:0]  req;
    logic [15:0] cos;
    logic        ready;
    logic        exp_valid;
    logic [2:0]  exp_bin;
  } vec_t;

  typedef struct {
    logic       valid;
    logic [7:0] hot;
    logic [2:0] bin;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  ldl_round_pri_arb dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cos   (cos),
    .ready (ready),
    .hot   (hot),
    .bin   (bin),
    .valid (valid)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue the expected output for the cycle that follows the drive.
  task automatic pushExpected(input logic v, input logic [2:0] b, input string name);
    exp_t e;
    e.valid = v;
    e.bin   = v ? b : 3'd0;
    e.hot   = v ? (8'd1 << b) : 8'd0;
    e.name  = name;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the outputs now.
  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard: queue empty, actual valid=%0b hot=%02h bin=%0d", valid, hot, bin);
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (valid !== e.valid) begin
      n_fail++;
      $display("[TB] FAIL %s valid: actual %0b required %0b", e.name, valid, e.valid);
    end
    n_checks++;
    if (hot !== e.hot) begin
      n_fail++;
      $display("[TB] FAIL %s hot: actual %02h required %02h", e.name, hot, e.hot);
    end
    n_checks++;
    if (bin !== e.bin) begin
      n_fail++;
      $display("[TB] FAIL %s bin: actual %0d required %0d", e.name, bin, e.bin);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then check after the next rising edge.
  task automatic applyStimulus(input logic [7:0] r, input logic [15:0] c, input logic rdy,
                               input logic ev, input logic [2:0] eb, input string name);
    @(negedge clk);
    req   = r;
    cos   = c;
    ready = rdy;
    pushExpected(ev, eb, name);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input logic [7:0] r, input logic [15:0] c, input logic rdy,
                        input logic ev, input logic [2:0] eb);
    vec_t v;
    v.req       = r;
    v.cos       = c;
    v.ready     = rdy;
    v.exp_valid = ev;
    v.exp_bin   = eb;
    vecs.push_back(v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    cos      = '0;
    ready    = 1'b1;

    // Pointer starts at 7 after reset, so the first search begins at 0.
    addVec(8'h00, 16'h0000, 1'b1, 1'b0, 3'd0);
    addVec(8'h00, 16'h0000, 1'b1, 1'b0, 3'd0);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd0);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd2);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd5);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd7);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd0);
    addVec(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd2);
    addVec(8'h00, 16'h0000, 1'b1, 1'b0, 3'd0);
    // cos = {3,2,1,0,3,2,1,0}: only 3 and 7 in the top class; pointer held at 2.
    addVec(8'hff, 16'he4e4, 1'b1, 1'b1, 3'd3);
    addVec(8'hff, 16'he4e4, 1'b1, 1'b1, 3'd7);
    addVec(8'hff, 16'he4e4, 1'b1, 1'b1, 3'd3);
    addVec(8'hff, 16'he4e4, 1'b1, 1'b1, 3'd7);
    // cos = {0,2,1,0,0,2,1,0}: 2 and 6 share the top class.
    addVec(8'hff, 16'h2424, 1'b1, 1'b1, 3'd2);
    addVec(8'hff, 16'h2424, 1'b1, 1'b1, 3'd6);
    addVec(8'hff, 16'h2424, 1'b1, 1'b1, 3'd2);
    // cos = {0,0,1,0,0,0,1,0}: 1 and 5 share the top class.
    addVec(8'hff, 16'h0404, 1'b1, 1'b1, 3'd5);
    addVec(8'hff, 16'h0404, 1'b1, 1'b1, 3'd1);
    addVec(8'hff, 16'h0404, 1'b1, 1'b1, 3'd5);
    // A sole requester keeps winning even though it was last granted.
    addVec(8'h10, 16'h0000, 1'b1, 1'b1, 3'd4);
    addVec(8'h10, 16'h0000, 1'b1, 1'b1, 3'd4);

    // Reset state while rst is held.
    repeat (2) @(posedge clk);
    #1;
    pushExpected(1'b0, 3'd0, "reset");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].req, vecs[i].cos, vecs[i].ready,
                    vecs[i].exp_valid, vecs[i].exp_bin, $sformatf("vec%0d", i));
    end

    // Back-pressure: pointer is 4, first grant 5, then frozen while req churns.
    applyStimulus(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd5, "bp_first");
    applyStimulus(8'h02, 16'h0000, 1'b0, 1'b1, 3'd5, "bp_hold0");
    applyStimulus(8'hff, 16'hffff, 1'b0, 1'b1, 3'd5, "bp_hold1");
    applyStimulus(8'h00, 16'h0000, 1'b0, 1'b1, 3'd5, "bp_hold2");
    applyStimulus(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd7, "bp_resume");
    applyStimulus(8'ha5, 16'h0000, 1'b1, 1'b1, 3'd0, "bp_next");

    // ready is ignored while nothing is held; a stalled grant survives req dropping.
    applyStimulus(8'h00, 16'h0000, 1'b1, 1'b0, 3'd0, "idle");
    applyStimulus(8'ha5, 16'h0000, 1'b0, 1'b1, 3'd2, "load_when_empty");
    applyStimulus(8'h00, 16'h0000, 1'b0, 1'b1, 3'd2, "no_drop_protect");

    // Mid-operation reset clears outputs without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    pushExpected(1'b0, 3'd0, "async_reset");
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hff, 16'h0000, 1'b1, 1'b1, 3'd0, "post_reset0");
    applyStimulus(8'hff, 16'h0000, 1'b1, 1'b1, 3'd1, "post_reset1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
